// File: rtl/qmult_seq_pkg.sv
// Purpose : shared sign-magnitude fixed-point constants and the multiplier FSM states.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Shared with the divider and adder blocks so all fixed-point arithmetic agrees on
// the default word layout: bit N-1 is the sign, bits N-2:0 are the magnitude, Q of
// which are fractional.
package qmult_seq_pkg;

  localparam int FXP_Q        = 15;           // fractional bits
  localparam int FXP_N        = 32;           // total word width
  localparam int FXP_SIGN_POS = FXP_N - 1;    // sign bit position
  localparam int FXP_MAG_MSB  = FXP_N - 2;    // magnitude field is [FXP_MAG_MSB:0]

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } qmult_state_e;

endpackage

// File: rtl/qmult_seq.sv
// Purpose : sequential shift-add multiplier for sign-magnitude Q-format words.
// Latency : complete drops for exactly N-1 cycles after the accept edge, operand independent.
// Backpressure: start is honoured only while complete=1; start/operands are ignored while busy.
//
// Ports:
//   clk, rst                 - rising-edge clock, synchronous active-high reset
//   multiplicand, multiplier - sign-magnitude operands, sampled only at accept
//   start                    - request a multiply (held high => back-to-back runs)
//   product_out, overflow    - result and magnitude-overflow flag, held until next completion
//   complete                 - high while idle; result valid
module qmult_seq
  import qmult_seq_pkg::*;
#(
  parameter int Q = FXP_Q,
  parameter int N = FXP_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  input  logic         start,
  output logic [N-1:0] product_out,
  output logic         complete,
  output logic         overflow
);

  localparam int MW = N - 1;        // magnitude width
  localparam int AW = 2 * MW;       // full-precision accumulator width
  localparam int CW = $clog2(N);    // iteration counter width

  qmult_state_e   state_q, state_d;
  logic [AW-1:0]  mcand_q, mcand_d;   // multiplicand magnitude, shifted left each iteration
  logic [MW-1:0]  mplier_q, mplier_d; // multiplier magnitude, shifted right each iteration
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sign_q, sign_d;
  logic [N-1:0]   prod_q, prod_d;
  logic           ovf_q, ovf_d;

  logic [AW-1:0]  acc_sum;
  logic [MW-1:0]  res_mag;

  // Partial-product add for the current multiplier LSB.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {AW{1'b0}});
  // Truncate: drop Q fractional guard bits, keep the N-1 magnitude bits above them.
  assign res_mag = acc_sum[MW-1+Q:Q];

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{(AW-MW){1'b0}}, multiplicand[N-2:0]};
          mplier_d = multiplier[N-2:0];
          acc_d    = '0;
          cnt_d    = CW'(N - 1);
          sign_d   = multiplicand[N-1] ^ multiplier[N-1];
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q == CW'(1)) begin
          // Final iteration: publish result. No saturation on overflow; the
          // sign is suppressed for a zero magnitude to avoid negative zero.
          prod_d  = {sign_q & (|res_mag), res_mag};
          ovf_d   = |acc_sum[AW-1:MW+Q];
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
    end
  end

  assign complete    = (state_q == ST_IDLE);
  assign product_out = prod_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_qmult_seq.sv
// Bench for qmult_seq (Q=15, N=32): directed vectors with literal expectations,
// plus a cycle-by-cycle comparison against an arithmetic reference model.
module tb_qmult_seq;

  localparam int Q   = 15;
  localparam int N   = 32;
  localparam int LAT = N - 1;

  logic        clk;
  logic        rst;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        start;
  logic [31:0] product_out;
  logic        complete;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  qmult_seq #(.Q(Q), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .start        (start),
    .product_out  (product_out),
    .complete     (complete),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: full-precision product of the magnitudes, then Q-format truncation.
  // Returns {overflow, sign, magnitude[30:0]}.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] m;
    logic        ovf;
    logic        sgn;
    p   = {33'd0, a[30:0]} * {33'd0, b[30:0]};
    m   = p >> Q;
    ovf = ((p >> (N - 1 + Q)) != 64'd0);
    sgn = (a[31] ^ b[31]) && (m[30:0] != 31'd0);
    return {ovf, sgn, m[30:0]};
  endfunction

  // Model: idle/busy tracked as a remaining-cycle count; result appears when it reaches zero.
  logic        model_ok = 1'b0;
  logic        m_complete;
  logic [31:0] m_prod;
  logic        m_ovf;
  logic [32:0] m_pending;
  int          busy_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      model_ok   = 1'b1;
      busy_left  = 0;
      m_prod     = 32'd0;
      m_ovf      = 1'b0;
    end else if (model_ok) begin
      if (busy_left == 0) begin
        if (start) begin
          m_pending = ref_mul(multiplicand, multiplier);
          busy_left = LAT;
        end
      end else begin
        busy_left--;
        if (busy_left == 0) begin
          m_prod = m_pending[31:0];
          m_ovf  = m_pending[32];
        end
      end
    end
    m_complete = (busy_left == 0);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cmp_complete", {63'd0, complete}, {63'd0, m_complete});
      chk("cmp_product",  {32'd0, product_out}, {32'd0, m_prod});
      chk("cmp_overflow", {63'd0, overflow}, {63'd0, m_ovf});
    end
  end

  // Entered and left at posedge+1 with complete=1. Operands are scrambled and a
  // stray start is pulsed while busy; neither may affect the result.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_p, input logic exp_o);
    int cyc;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = 32'hDEADBEEF;
    multiplier   = 32'h7FFFFFFF;
    chk({nm, "_busy"}, {63'd0, complete}, 64'd0);
    cyc = 0;
    while (!complete && cyc < 100) begin
      start = (cyc == 5);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_latency"},  cyc, LAT);
    chk({nm, "_product"},  {32'd0, product_out}, {32'd0, exp_p});
    chk({nm, "_overflow"}, {63'd0, overflow}, {63'd0, exp_o});
  endtask

  initial begin
    int cyc;
    rst          = 1'b1;
    start        = 1'b1;   // rst must override start
    multiplicand = 32'h0000C000;
    multiplier   = 32'h00010000;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("reset_complete", {63'd0, complete}, 64'd1);
    chk("reset_product",  {32'd0, product_out}, 64'd0);
    chk("reset_overflow", {63'd0, overflow}, 64'd0);
    rst = 1'b0;

    do_op("pos_x_pos",  32'h0000C000, 32'h00010000, 32'h00018000, 1'b0);
    do_op("neg_x_pos",  32'h8000C000, 32'h00010000, 32'h80018000, 1'b0);
    do_op("neg_x_neg",  32'h8000C000, 32'h80010000, 32'h00018000, 1'b0);
    do_op("ovf_trunc",  32'h40000000, 32'h00010000, 32'h00000000, 1'b1);
    do_op("max_x_max",  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFE0000, 1'b1);
    do_op("zero_neg",   32'h00000000, 32'h80008000, 32'h00000000, 1'b0);
    do_op("neg_x_pos2", 32'h8000C000, 32'h00010000, 32'h80018000, 1'b0);
    do_op("tiny_nozero", 32'h80000001, 32'h00000001, 32'h00000000, 1'b0);

    // Prior result nonzero so the reset clear is visible.
    do_op("pre_reset",  32'h8000C000, 32'h00010000, 32'h80018000, 1'b0);
    multiplicand = 32'h0000C000;
    multiplier   = 32'h00010000;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_complete", {63'd0, complete}, 64'd1);
    chk("midrst_product",  {32'd0, product_out}, 64'd0);
    chk("midrst_overflow", {63'd0, overflow}, 64'd0);
    do_op("post_reset", 32'h0000C000, 32'h00010000, 32'h00018000, 1'b0);

    // Back-to-back with start held high; operands change during each busy period.
    multiplicand = 32'h00010000;   // 2.0
    multiplier   = 32'h80018000;   // -3.0
    start        = 1'b1;
    @(posedge clk); #1;
    multiplicand = 32'h00004000;   // 0.5, for the second run
    multiplier   = 32'h00004000;   // 0.5
    cyc = 0;
    while (!complete && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b1_latency", cyc, LAT);
    chk("b2b1_product", {32'd0, product_out}, 64'h80030000);
    @(posedge clk); #1;
    chk("b2b2_reaccept", {63'd0, complete}, 64'd0);
    start        = 1'b0;
    multiplicand = 32'h7FFFFFFF;
    multiplier   = 32'h7FFFFFFF;
    cyc = 0;
    while (!complete && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b2_latency",  cyc, LAT);
    chk("b2b2_product",  {32'd0, product_out}, 64'h00002000);
    chk("b2b2_overflow", {63'd0, overflow}, 64'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
